// File: rtl/req_arbiter_4.sv
// Four-requester arbiter: registered one-hot grant, owner release/abort/hold timeout, one dead cycle.
// Define ROUND_ROBIN_EN for rotating priority; otherwise fixed priority 3 > 2 > 1 > 0.
module req_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

   localparam bit HoldEn = (MAX_HOLD != 0);
   // With the timeout disabled the counter simply parks at all-ones.
   localparam logic [CNT_W-1:0] HoldLast = HoldEn ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             timeout_q, timeout_d;
   logic [1:0]       win_id;

`ifdef ROUND_ROBIN_EN
   logic [1:0] last_id_q, last_id_d;
   logic [1:0] scan_id;

   // Scan lowest priority first so the highest-priority hit is written last.
   always_comb begin
      win_id  = 2'd0;
      scan_id = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         scan_id = last_id_q - 2'(k);
         if (req[scan_id]) begin
            win_id = scan_id;
         end
      end
   end
`else
   always_comb begin
      win_id = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (req[i]) begin
            win_id = 2'(i);
         end
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
`ifdef ROUND_ROBIN_EN
      last_id_d = last_id_q;
`endif
      unique case (state_q)
         StIdle, StGap: begin
            if (req != 4'b0000) begin
               state_d  = StBusy;
               gnt_d    = 4'b0001 << win_id;
               gnt_id_d = win_id;
               hold_d   = '0;
`ifdef ROUND_ROBIN_EN
               last_id_d = win_id;
`endif
            end else begin
               state_d  = StIdle;
               gnt_d    = 4'b0000;
               gnt_id_d = 2'b00;
               hold_d   = '0;
            end
         end
         StBusy: begin
            if (!req[gnt_id_q] || done || (HoldEn && (hold_q == HoldLast))) begin
               state_d   = StGap;
               gnt_d     = 4'b0000;
               gnt_id_d  = 2'b00;
               hold_d    = '0;
               // Abort and release take precedence over the hold limit.
               timeout_d = req[gnt_id_q] && !done;
            end else if (hold_q != HoldLast) begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = StIdle;
            gnt_d    = 4'b0000;
            gnt_id_d = 2'b00;
            hold_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         gnt_q     <= 4'b0000;
         gnt_id_q  <= 2'b00;
         hold_q    <= '0;
         timeout_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
         last_id_q <= 2'b00;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`ifdef ROUND_ROBIN_EN
         last_id_q <= last_id_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = |gnt_q;
   assign timeout   = timeout_q;

   gnt_onehot_a: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_q));
   gnt_state_a: assert property (@(posedge clk) disable iff (!reset_n)
      (gnt_q != 4'b0000) == (state_q == StBusy));
   timeout_gap_a: assert property (@(posedge clk) disable iff (!reset_n)
      timeout_q |-> (state_q == StGap));

endmodule

// File: tb/tb_req_arbiter_4.sv
// Randomised bench for req_arbiter_4 against an owner/held-cycles model, plus literal directed checks.
module tb_req_arbiter_4;
   localparam int unsigned MaxHold = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   always #5 clk = ~clk;

   req_arbiter_4 #(.MAX_HOLD(MaxHold), .CNT_W(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .done     (done),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .gnt_valid(gnt_valid),
      .timeout  (timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: current owner (-1 = none), cycles the grant has been visible, last owner, timeout pulse.
   int m_owner = -1;
   int m_held  = 0;
   int m_last  = 0;
   bit m_to    = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 0;
      m_to    = 1'b0;
   endtask

   function automatic int pick(input logic [3:0] r);
      int base;
`ifdef ROUND_ROBIN_EN
      base = m_last;
`else
      base = 0;
`endif
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (base - k + 8) % 4;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic [3:0] r, input logic d);
      int w;
      m_to = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner] || d) begin
            m_owner = -1;
         end else if (MaxHold != 0 && m_held == int'(MaxHold)) begin
            m_owner = -1;
            m_to    = 1'b1;
         end else begin
            m_held++;
         end
      end else begin
         w = pick(r);
         if (w >= 0) begin
            m_owner = w;
            m_held  = 1;
            m_last  = w;
         end
      end
   endtask

   task automatic compare_model();
      check("model_gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
      check("model_gnt_id", int'(gnt_id), (m_owner >= 0) ? m_owner : 0);
      check("model_gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
      check("model_timeout", int'(timeout), int'(m_to));
   endtask

   // One clock: drive at negedge (also releasing any pending reset), advance model, compare.
   task automatic step(input logic [3:0] r, input logic d);
      @(negedge clk);
      reset_n = 1'b1;
      req     = r;
      done    = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
      compare_model();
   endtask

   // Called just after a compare (posedge+1): reset lands between edges.
   task automatic async_reset();
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_gnt", int'(gnt), 0);
      check("rst_gnt_valid", int'(gnt_valid), 0);
      check("rst_gnt_id", int'(gnt_id), 0);
      check("rst_timeout", int'(timeout), 0);
      model_reset();
   endtask

   initial begin
      int exp_seq[5];
      logic [3:0] r;
      logic d;

      reset_n = 1'b0;
      req     = 4'b1111;
      done    = 1'b0;
      #12;
      check("por_gnt", int'(gnt), 0);
      check("por_gnt_id", int'(gnt_id), 0);
      check("por_gnt_valid", int'(gnt_valid), 0);
      check("por_timeout", int'(timeout), 0);
      model_reset();

      // First grant after reset goes to requester 3.
      step(4'b1111, 1'b0);
      check("first_gnt", int'(gnt), 4'b1000);
      check("first_gnt_id", int'(gnt_id), 3);
      check("first_valid", int'(gnt_valid), 1);

      // Reset mid-grant, then requesters 1 and 0 compete.
      async_reset();
      step(4'b0011, 1'b0);
      check("after_rst_gnt", int'(gnt), 4'b0010);

      // Release by done, one dead cycle, then the next winner.
      async_reset();
      step(4'b0110, 1'b0);
      check("own2_gnt", int'(gnt), 4'b0100);
      step(4'b0110, 1'b1);
      check("release_gap_gnt", int'(gnt), 0);
      check("release_gap_to", int'(timeout), 0);
      step(4'b0110, 1'b0);
`ifdef ROUND_ROBIN_EN
      check("after_release_gnt", int'(gnt), 4'b0010);
`else
      check("after_release_gnt", int'(gnt), 4'b0100);
`endif

      // Hold timeout: exactly MaxHold granted cycles, one timeout gap, then re-grant.
      async_reset();
      for (int i = 0; i < int'(MaxHold); i++) begin
         step(4'b0001, 1'b0);
         check("hold_gnt", int'(gnt), 4'b0001);
         check("hold_to", int'(timeout), 0);
      end
      step(4'b0001, 1'b0);
      check("to_gnt", int'(gnt), 0);
      check("to_pulse", int'(timeout), 1);
      step(4'b0001, 1'b0);
      check("regrant_gnt", int'(gnt), 4'b0001);
      check("regrant_to", int'(timeout), 0);

      // Owner abort.
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0100, 1'b0);
      check("abort_own_gnt", int'(gnt), 4'b0100);
      step(4'b0000, 1'b0);
      check("abort_gnt", int'(gnt), 0);
      check("abort_to", int'(timeout), 0);
      step(4'b0000, 1'b0);
      check("abort_idle_gnt", int'(gnt), 0);

      // All requesting, each grant released by done.
`ifdef ROUND_ROBIN_EN
      exp_seq = '{3, 2, 1, 0, 3};
`else
      exp_seq = '{3, 3, 3, 3, 3};
`endif
      async_reset();
      step(4'b1111, 1'b0);
      check("seq_id0", int'(gnt_id), exp_seq[0]);
      for (int i = 1; i < 5; i++) begin
         step(4'b1111, 1'b1);
         check("seq_gap", int'(gnt_valid), 0);
         step(4'b1111, 1'b0);
         check("seq_id", int'(gnt_id), exp_seq[i]);
      end

      // Random traffic: sticky requests so holds reach the timeout, sparse done, rare resets.
      r = 4'b0000;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
         d = ($urandom_range(7) == 0);
         if ($urandom_range(149) == 0) async_reset();
         step(r, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
